// File: rtl/fetch_inst_queue.sv
// Two-wide circular instruction queue between fetch and the decoder pair.
// Takes up to two instructions per cycle, presents the two oldest, and is emptied in one cycle by kill.
module fetch_inst_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               kill,
    input  logic               in_valid1,
    input  logic               in_valid2,
    input  logic [31:0]        in_inst1,
    input  logic [31:0]        in_pc1,
    input  logic [31:0]        in_inst2,
    input  logic [31:0]        in_pc2,
    output logic               enq_ready,
    output logic               out_valid1,
    output logic               out_valid2,
    output logic [31:0]        out_inst1,
    output logic [31:0]        out_pc1,
    output logic [31:0]        out_inst2,
    output logic [31:0]        out_pc2,
    input  logic [1:0]         deq_num,
    output logic [PTR_W:0]     count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_enq_ready;
    logic             w_enq_fire;
    logic [1:0]       w_enq_n;
    logic [1:0]       w_deq_req;
    logic [1:0]       w_deq_eff;
    logic [PTR_W-1:0] w_head_p1;
    logic [PTR_W-1:0] w_tail_p1;

    // Ready needs room for a full pair, judged on registered occupancy only.
    always_comb begin
        w_enq_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(2);
        w_enq_fire  = w_enq_ready & in_valid1 & ~kill;
        w_enq_n     = 2'd0;
        if (w_enq_fire) begin
            w_enq_n = in_valid2 ? 2'd2 : 2'd1;
        end
        // deq_num of 3 behaves as 2; requests beyond occupancy are clamped.
        w_deq_req = deq_num[1] ? 2'd2 : {1'b0, deq_num[0]};
        w_deq_eff = w_deq_req;
        if (r_count < CNT_W'(w_deq_req)) begin
            w_deq_eff = 2'(r_count);
        end
        w_head_p1 = r_head + PTR_W'(1);
        w_tail_p1 = r_tail + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (kill) begin
            // Flush resets pointers only; storage keeps stale contents.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_fire) begin
                r_inst[r_tail] <= in_inst1;
                r_pc[r_tail]   <= in_pc1;
                if (in_valid2) begin
                    r_inst[w_tail_p1] <= in_inst2;
                    r_pc[w_tail_p1]   <= in_pc2;
                end
            end
            r_tail  <= r_tail + PTR_W'(w_enq_n);
            r_head  <= r_head + PTR_W'(w_deq_eff);
            r_count <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_deq_eff);
        end
    end

    always_comb begin
        enq_ready  = w_enq_ready;
        out_valid1 = r_count >= CNT_W'(1);
        out_valid2 = r_count >= CNT_W'(2);
        out_inst1  = r_inst[r_head];
        out_pc1    = r_pc[r_head];
        out_inst2  = r_inst[w_head_p1];
        out_pc2    = r_pc[w_head_p1];
        count      = r_count;
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue: reset, pair enqueue, full/back-pressure,
// streaming wrap, kill, dequeue clamping and asynchronous reset.
module tb_fetch_inst_queue;

    logic        clk;
    logic        reset;
    logic        kill;
    logic        in_valid1;
    logic        in_valid2;
    logic [31:0] in_inst1;
    logic [31:0] in_pc1;
    logic [31:0] in_inst2;
    logic [31:0] in_pc2;
    logic        enq_ready;
    logic        out_valid1;
    logic        out_valid2;
    logic [31:0] out_inst1;
    logic [31:0] out_pc1;
    logic [31:0] out_inst2;
    logic [31:0] out_pc2;
    logic [1:0]  deq_num;
    logic [3:0]  count;

    int n_cmp;
    int n_fail;

    fetch_inst_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .kill      (kill),
        .in_valid1 (in_valid1),
        .in_valid2 (in_valid2),
        .in_inst1  (in_inst1),
        .in_pc1    (in_pc1),
        .in_inst2  (in_inst2),
        .in_pc2    (in_pc2),
        .enq_ready (enq_ready),
        .out_valid1(out_valid1),
        .out_valid2(out_valid2),
        .out_inst1 (out_inst1),
        .out_pc1   (out_pc1),
        .out_inst2 (out_inst2),
        .out_pc2   (out_pc2),
        .deq_num   (deq_num),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        in_inst1  = '0;
        in_pc1    = '0;
        in_inst2  = '0;
        in_pc2    = '0;
        deq_num   = 2'd0;
        kill      = 1'b0;
    endtask

    task automatic drive(input logic v1, input logic v2,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic [31:0] i2, input logic [31:0] p2,
                         input logic [1:0] dq);
        in_valid1 = v1;
        in_valid2 = v2;
        in_inst1  = i1;
        in_pc1    = p1;
        in_inst2  = i2;
        in_pc2    = p2;
        deq_num   = dq;
        kill      = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b exp 1", enq_ready); end
        n_cmp++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got %b%b exp 00", out_valid1, out_valid2); end
        n_cmp++; if (out_inst1 !== 32'h0 || out_pc1 !== 32'h0 || out_inst2 !== 32'h0 || out_pc2 !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h exp zeros", out_inst1, out_pc1, out_inst2, out_pc2);
        end
    endtask

    task automatic test_pair();
        do_reset();
        drive(1'b1, 1'b1, 32'h0000_0013, 32'h0000_1000, 32'h0010_0093, 32'h0000_1004, 2'd0);
        n_cmp++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL pair_no_bypass: got %b exp 0", out_valid1); end
        tick();
        idle();
        n_cmp++; if (count !== 4'd2) begin n_fail++; $display("FAIL pair_count: got %0d exp 2", count); end
        n_cmp++; if (out_valid1 !== 1'b1 || out_valid2 !== 1'b1) begin n_fail++; $display("FAIL pair_valids: got %b%b exp 11", out_valid1, out_valid2); end
        n_cmp++; if (out_pc1 !== 32'h0000_1000) begin n_fail++; $display("FAIL pair_pc1: got %h exp 00001000", out_pc1); end
        n_cmp++; if (out_inst1 !== 32'h0000_0013) begin n_fail++; $display("FAIL pair_inst1: got %h exp 00000013", out_inst1); end
        n_cmp++; if (out_inst2 !== 32'h0010_0093) begin n_fail++; $display("FAIL pair_inst2: got %h exp 00100093", out_inst2); end
        n_cmp++; if (out_pc2 !== 32'h0000_1004) begin n_fail++; $display("FAIL pair_pc2: got %h exp 00001004", out_pc2); end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'hA000 + 32'(2*k), 32'h100 + 32'(8*k),
                  32'hA001 + 32'(2*k), 32'h104 + 32'(8*k), 2'd0);
            tick();
        end
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d exp 8", count); end
        n_cmp++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_enq_ready: got %b exp 0", enq_ready); end
        // Held pair while full must not overwrite anything.
        drive(1'b1, 1'b1, 32'hDEAD_0000, 32'h900, 32'hDEAD_0001, 32'h904, 2'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL hold_count[%0d]: got %0d exp 8", k, count); end
            n_cmp++; if (out_pc1 !== 32'h100 || out_inst1 !== 32'hA000 || out_pc2 !== 32'h104) begin
                n_fail++; $display("FAIL hold_head[%0d]: got %h %h %h exp 00000100 0000a000 00000104", k, out_pc1, out_inst1, out_pc2);
            end
        end
        // Dequeue one while still holding the pair: 8 -> 7, nothing written.
        deq_num = 2'd1;
        tick();
        n_cmp++; if (count !== 4'd7 || enq_ready !== 1'b0) begin n_fail++; $display("FAIL deq_to7: got cnt %0d rdy %b exp 7 0", count, enq_ready); end
        n_cmp++; if (out_pc1 !== 32'h104) begin n_fail++; $display("FAIL deq_to7_pc1: got %h exp 00000104", out_pc1); end
        // count=7: enq_ready=0 blocks the pair; dequeue still applies.
        tick();
        n_cmp++; if (count !== 4'd6 || enq_ready !== 1'b1) begin n_fail++; $display("FAIL seven_block: got cnt %0d rdy %b exp 6 1", count, enq_ready); end
        n_cmp++; if (out_pc1 !== 32'h108) begin n_fail++; $display("FAIL seven_block_pc1: got %h exp 00000108", out_pc1); end
        idle();
    endtask

    task automatic test_stream_wrap();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, 32'hC000 + 32'(k), 32'h2000 + 32'(4*k), 32'h0, 32'h0, 2'd1);
            tick();
            n_cmp++; if (count !== 4'd1 || out_valid1 !== 1'b1) begin
                n_fail++; $display("FAIL stream_count[%0d]: got cnt %0d v1 %b exp 1 1", k, count, out_valid1);
            end
            n_cmp++; if (out_pc1 !== 32'h2000 + 32'(4*k) || out_inst1 !== 32'hC000 + 32'(k)) begin
                n_fail++; $display("FAIL stream_head[%0d]: got %h %h exp %h %h", k, out_pc1, out_inst1, 32'h2000 + 32'(4*k), 32'hC000 + 32'(k));
            end
        end
        idle();
        deq_num = 2'd1;
        tick();
        idle();
        n_cmp++; if (count !== 4'd0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got cnt %0d v1 %b exp 0 0", count, out_valid1); end
    endtask

    task automatic test_kill();
        do_reset();
        drive(1'b1, 1'b1, 32'h1, 32'h3000, 32'h2, 32'h3004, 2'd0); tick();
        drive(1'b1, 1'b1, 32'h3, 32'h3008, 32'h4, 32'h300C, 2'd0); tick();
        drive(1'b1, 1'b0, 32'h5, 32'h3010, 32'h0, 32'h0, 2'd0);    tick();
        n_cmp++; if (count !== 4'd5) begin n_fail++; $display("FAIL kill_pre_count: got %0d exp 5", count); end
        drive(1'b1, 1'b1, 32'h6, 32'h3014, 32'h7, 32'h3018, 2'd2);
        kill = 1'b1;
        tick();
        idle();
        n_cmp++; if (count !== 4'd0 || out_valid1 !== 1'b0 || enq_ready !== 1'b1) begin
            n_fail++; $display("FAIL kill_flush: got cnt %0d v1 %b rdy %b exp 0 0 1", count, out_valid1, enq_ready);
        end
        drive(1'b1, 1'b0, 32'h0000_4444, 32'h4000, 32'h0, 32'h0, 2'd0);
        tick();
        idle();
        n_cmp++; if (count !== 4'd1 || out_pc1 !== 32'h4000 || out_inst1 !== 32'h0000_4444 || out_valid2 !== 1'b0) begin
            n_fail++; $display("FAIL kill_reenq: got cnt %0d pc %h inst %h v2 %b exp 1 00004000 00004444 0", count, out_pc1, out_inst1, out_valid2);
        end
    endtask

    task automatic test_deq_clamp();
        do_reset();
        drive(1'b1, 1'b0, 32'h50, 32'h5000, 32'h0, 32'h0, 2'd0); tick();
        idle();
        deq_num = 2'd2;
        tick();
        n_cmp++; if (count !== 4'd0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL clamp_one: got cnt %0d v1 %b exp 0 0", count, out_valid1); end
        // Over-request on empty must not underflow.
        tick();
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL clamp_empty: got %0d exp 0", count); end
        drive(1'b1, 1'b1, 32'h60, 32'h6000, 32'h61, 32'h6004, 2'd0); tick();
        drive(1'b1, 1'b0, 32'h62, 32'h6008, 32'h0, 32'h0, 2'd0);     tick();
        idle();
        n_cmp++; if (count !== 4'd3) begin n_fail++; $display("FAIL clamp_three: got %0d exp 3", count); end
        deq_num = 2'd3;
        tick();
        idle();
        n_cmp++; if (count !== 4'd1 || out_pc1 !== 32'h6008) begin n_fail++; $display("FAIL deq3: got cnt %0d pc %h exp 1 00006008", count, out_pc1); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 1'b1, 32'h70, 32'h7000, 32'h71, 32'h7004, 2'd0); tick();
        n_cmp++; if (count !== 4'd2) begin n_fail++; $display("FAIL async_pre: got %0d exp 2", count); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (count !== 4'd0 || out_valid1 !== 1'b0 || out_pc1 !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got cnt %0d v1 %b pc %h exp 0 0 00000000", count, out_valid1, out_pc1);
        end
        tick();
        reset = 1'b0;
        idle();
        tick();
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL async_lost_enq: got %0d exp 0", count); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_pair();
        test_full_backpressure();
        test_stream_wrap();
        test_kill();
        test_deq_clamp();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
